cint_sequencer: RTL

Executes the multi-cycle entry sequence of the CINT (software interrupt) instruction once the instruction decoder has recognised it and raised `enable_cint`. It pushes the return address onto the stack, fetches the 16-bit handler address from the vector table in the IOP low page, then loads PC and SP in a single cycle. It sits between the decoder chain and the memory port, and stalls the decoder via `busy` while the sequence runs.

---
 rtl/norz_cint_pkg.sv | 45 ++++
 rtl/cint_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/norz_cint_pkg.sv
// norz_cint_pkg: shared definitions for the CINT entry sequencer.
//   - state enum (PUSH_FL exists only when CINT_PUSH_FLAGS_EN is defined)
//   - default vector table base in the IOP low page
//   - address/data widths and stack frame size (2 or 3 bytes, macro selected)
//   - vector_addr(): table entry address, wrapping modulo 2^16
// Configuration macro: CINT_PUSH_FLAGS_EN
package norz_cint_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] VECTOR_BASE_DEFAULT = 16'hFF00;

`ifdef CINT_PUSH_FLAGS_EN
  localparam logic [ADDR_W-1:0] FRAME_SIZE = 16'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_FL  = 3'd1,
    ST_PUSH_HI  = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_FETCH_LO = 3'd4,
    ST_FETCH_HI = 3'd5,
    ST_LOAD     = 3'd6
  } cint_state_t;
`else
  localparam logic [ADDR_W-1:0] FRAME_SIZE = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_HI  = 3'd2,
    ST_PUSH_LO  = 3'd3,
    ST_FETCH_LO = 3'd4,
    ST_FETCH_HI = 3'd5,
    ST_LOAD     = 3'd6
  } cint_state_t;
`endif

  // Each table entry is two bytes; the sum wraps naturally at 16 bits.
  function automatic logic [ADDR_W-1:0] vector_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [3:0] vec);
    vector_addr = base + {11'd0, vec, 1'b0};
  endfunction

endpackage

// File: rtl/cint_sequencer.sv
// cint_sequencer: runs the CINT entry sequence after the decoder raises
// enable_cint: push return address (and flags when CINT_PUSH_FLAGS_EN is
// defined), fetch the 16-bit handler address from the vector table, then
// strobe pc_load/sp_load/int_mask_set together for one cycle.
//
// Ports:
//   clk, not_reset          clock, asynchronous active-low reset
//   enable_cint             one-cycle request (ignored unless idle)
//   cint_vector, pc_in,
//   sp_in, flags_in         operands latched on accept
//   mem_req/we/addr/wdata   memory port request side (all registered)
//   mem_rdata, mem_ack      memory port response; transfer on req&ack edge
//   pc_out, sp_out          new PC / SP, valid with the load strobes
//   pc_load, sp_load,
//   int_mask_set            coincident one-cycle strobes
//   busy                    high whenever not idle
//
// Configuration macro: CINT_PUSH_FLAGS_EN (adds the flags push, 3-byte frame).
module cint_sequencer
  import norz_cint_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE = VECTOR_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              not_reset,
  input  logic              enable_cint,
  input  logic [3:0]        cint_vector,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [DATA_W-1:0] flags_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_load,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_load,
  output logic              int_mask_set,
  output logic              busy
);

  cint_state_t       state;
  logic [3:0]        vec_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] sp_r;
  logic [DATA_W-1:0] lo_r;
  logic              xfer;

`ifndef CINT_PUSH_FLAGS_EN
  // flags are not pushed in this build
  logic unused_flags;
  assign unused_flags = ^flags_in;
`endif

  // mem_req is a register, so ack is only honoured while a request is up.
  assign xfer = mem_req & mem_ack;

  // Sequencer FSM; every output is registered and set for the state being entered.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state        <= ST_IDLE;
      vec_r        <= 4'd0;
      pc_r         <= 16'd0;
      sp_r         <= 16'd0;
      lo_r         <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 16'd0;
      mem_wdata    <= 8'd0;
      pc_out       <= 16'd0;
      pc_load      <= 1'b0;
      sp_out       <= 16'd0;
      sp_load      <= 1'b0;
      int_mask_set <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_cint) begin
            vec_r    <= cint_vector;
            pc_r     <= pc_in;
            sp_r     <= sp_in;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= sp_in - 16'd1;
`ifdef CINT_PUSH_FLAGS_EN
            state     <= ST_PUSH_FL;
            mem_wdata <= flags_in;
`else
            state     <= ST_PUSH_HI;
            mem_wdata <= pc_in[15:8];
`endif
          end
        end
`ifdef CINT_PUSH_FLAGS_EN
        ST_PUSH_FL: begin
          if (xfer) begin
            state     <= ST_PUSH_HI;
            mem_addr  <= sp_r - 16'd2;
            mem_wdata <= pc_r[15:8];
          end
        end
`endif
        ST_PUSH_HI: begin
          // the low byte always lands at the bottom of the frame
          if (xfer) begin
            state     <= ST_PUSH_LO;
            mem_addr  <= sp_r - FRAME_SIZE;
            mem_wdata <= pc_r[7:0];
          end
        end
        ST_PUSH_LO: begin
          if (xfer) begin
            state     <= ST_FETCH_LO;
            mem_we    <= 1'b0;
            mem_addr  <= vector_addr(VECTOR_BASE, vec_r);
            mem_wdata <= 8'd0;
          end
        end
        ST_FETCH_LO: begin
          if (xfer) begin
            state    <= ST_FETCH_HI;
            lo_r     <= mem_rdata;
            mem_addr <= mem_addr + 16'd1;
          end
        end
        ST_FETCH_HI: begin
          if (xfer) begin
            state        <= ST_LOAD;
            mem_req      <= 1'b0;
            mem_addr     <= 16'd0;
            pc_out       <= {mem_rdata, lo_r};
            sp_out       <= sp_r - FRAME_SIZE;
            pc_load      <= 1'b1;
            sp_load      <= 1'b1;
            int_mask_set <= 1'b1;
          end
        end
        ST_LOAD: begin
          state        <= ST_IDLE;
          pc_load      <= 1'b0;
          sp_load      <= 1'b0;
          int_mask_set <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          pc_load      <= 1'b0;
          sp_load      <= 1'b0;
          int_mask_set <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
